// File: rtl/hms_pkg.sv
// Shared types, limits and seven-segment digit constants for the hours/minutes/seconds timekeeper.
package hms_pkg;

    typedef logic [6:0]  seg7_t;
    typedef logic [13:0] field_code_t;

    localparam int HRS_MAX = 23;
    localparam int MS_MAX  = 59;

    // Active-high segments, bit6..0 = g,f,e,d,c,b,a
    localparam seg7_t SEG_0 = 7'h3F;
    localparam seg7_t SEG_1 = 7'h06;
    localparam seg7_t SEG_2 = 7'h5B;
    localparam seg7_t SEG_3 = 7'h4F;
    localparam seg7_t SEG_4 = 7'h66;
    localparam seg7_t SEG_5 = 7'h6D;
    localparam seg7_t SEG_6 = 7'h7D;
    localparam seg7_t SEG_7 = 7'h07;
    localparam seg7_t SEG_8 = 7'h7F;
    localparam seg7_t SEG_9 = 7'h6F;

    function automatic seg7_t digit_to_seg(input logic [3:0] digit);
        case (digit)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return 7'h00;
        endcase
    endfunction

endpackage

// File: rtl/hms_bin2seg.sv
// Converts a 0..59 binary field into a two-digit seven-segment code, tens in [13:7], units in [6:0].
module hms_bin2seg
    import hms_pkg::*;
(
    input  logic [5:0]  bin_i,
    output field_code_t code_o
);

    logic [3:0] tens;
    logic [3:0] units;

    always_comb begin
        tens  = 4'(bin_i / 6'd10);
        units = 4'(bin_i % 6'd10);
    end

    assign code_o = {digit_to_seg(tens), digit_to_seg(units)};

endmodule

// File: rtl/hms_clock_display.sv
// 24-hour timekeeper with prescaler, run/hold, validated load and 12/24-hour seven-segment display.
// Optional alarm compiled in with HMS_ALARM_EN.
module hms_clock_display
    import hms_pkg::*;
#(
    parameter int unsigned CLK_DIV = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        mode12,
    input  logic        set_valid,
    input  logic [4:0]  set_hrs,
    input  logic [5:0]  set_min,
    input  logic [5:0]  set_sec,
`ifdef HMS_ALARM_EN
    input  logic [4:0]  alarm_hrs,
    input  logic [5:0]  alarm_min,
    output logic        alarm_hit,
`endif
    output logic        set_ready,
    output logic        set_err,
    output logic        sec_tick,
    output logic        pm,
    output logic [13:0] secCode,
    output logic [13:0] minCode,
    output logic [13:0] hrsCode
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [4:0]       hrs_q, hrs_d;
    logic [5:0]       min_q, min_d;
    logic [5:0]       sec_q, sec_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             ready_q;
    logic             tick_q, tick_d;
    logic             err_q, err_d;
    logic             xfer, load_ok, tick;
    logic [4:0]       hrs_disp;

    assign xfer    = set_valid & ready_q;
    assign load_ok = xfer && (set_hrs <= 5'(HRS_MAX)) && (set_min <= 6'(MS_MAX))
                          && (set_sec <= 6'(MS_MAX));
    assign tick    = run && (div_q == DIV_LAST);

    always_comb begin
        hrs_d = hrs_q;
        min_d = min_q;
        sec_d = sec_q;
        div_d = div_q;
        if (load_ok) begin
            hrs_d = set_hrs;
            min_d = set_min;
            sec_d = set_sec;
            div_d = '0;
        end else if (run) begin
            if (tick) begin
                div_d = '0;
                if (sec_q == 6'(MS_MAX)) begin
                    sec_d = '0;
                    if (min_q == 6'(MS_MAX)) begin
                        min_d = '0;
                        hrs_d = (hrs_q == 5'(HRS_MAX)) ? 5'd0 : hrs_q + 5'd1;
                    end else begin
                        min_d = min_q + 6'd1;
                    end
                end else begin
                    sec_d = sec_q + 6'd1;
                end
            end else begin
                div_d = div_q + 1'b1;
            end
        end
        // A coincident accepted load swallows the tick; a rejected one does not.
        tick_d = tick & ~load_ok;
        err_d  = xfer & ~load_ok;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hrs_q   <= '0;
            min_q   <= '0;
            sec_q   <= '0;
            div_q   <= '0;
            ready_q <= 1'b0;
            tick_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            hrs_q   <= hrs_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            div_q   <= div_d;
            ready_q <= 1'b1;
            tick_q  <= tick_d;
            err_q   <= err_d;
        end
    end

`ifdef HMS_ALARM_EN
    logic alarm_q, alarm_d;

    always_comb begin
        alarm_d = alarm_q;
        if ((load_ok || tick) && hrs_d == alarm_hrs && min_d == alarm_min && sec_d == 6'd0) begin
            alarm_d = 1'b1;
        end else if (hrs_d != hrs_q || min_d != min_q) begin
            alarm_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alarm_q <= 1'b0;
        end else begin
            alarm_q <= alarm_d;
        end
    end

    assign alarm_hit = alarm_q;
`endif

    always_comb begin
        hrs_disp = hrs_q;
        if (mode12) begin
            if (hrs_q == 5'd0) begin
                hrs_disp = 5'd12;
            end else if (hrs_q > 5'd12) begin
                hrs_disp = hrs_q - 5'd12;
            end
        end
    end

    assign set_ready = ready_q;
    assign set_err   = err_q;
    assign sec_tick  = tick_q;
    assign pm        = (hrs_q >= 5'd12);

    hms_bin2seg u_sec (.bin_i(sec_q),            .code_o(secCode));
    hms_bin2seg u_min (.bin_i(min_q),            .code_o(minCode));
    hms_bin2seg u_hrs (.bin_i({1'b0, hrs_disp}), .code_o(hrsCode));

endmodule
